// File: rtl/sad_eval_pkg.sv
// Shared widths, FSM state type and the popcount helper for the SAD error evaluator.
package sad_eval_pkg;

    localparam int IN_W  = 10;
    localparam int OUT_W = 3;
    localparam int CNT_W = IN_W + 1;
    localparam int SUM_W = IN_W + OUT_W;
    localparam int N_VEC = 2 ** IN_W;
    localparam int PC_W  = $clog2(OUT_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } eval_state_t;

    // Number of set bits in an OUT_W-bit response difference.
    function automatic logic [PC_W-1:0] popcount_out(input logic [OUT_W-1:0] x);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < OUT_W; i++) begin
            n = n + PC_W'(x[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sad_err_acc.sv
// Stage register for the sampled responses plus the four error accumulators.
module sad_err_acc
    import sad_eval_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             valid,
    input  logic [OUT_W-1:0] approx_in,
    input  logic [OUT_W-1:0] exact_in,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] abs_sum,
    output logic [SUM_W-1:0] hd_sum,
    output logic [OUT_W-1:0] wce
);

    logic [OUT_W-1:0] stage_a;
    logic [OUT_W-1:0] stage_e;
    logic             stage_vld;
    logic [OUT_W-1:0] abs_d;
    logic [OUT_W-1:0] xor_d;

    // Absolute and bitwise difference of the staged response pair.
    always_comb begin
        abs_d = (stage_a >= stage_e) ? (stage_a - stage_e) : (stage_e - stage_a);
        xor_d = stage_a ^ stage_e;
    end

    // Capture the responses of the current vector, then fold the previous one into the sums.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the stage is reset along with the sums so a mid-sweep reset leaves no stale entry.
        if (!rst_n) begin
            stage_a   <= '0;
            stage_e   <= '0;
            stage_vld <= 1'b0;
            err_cnt   <= '0;
            abs_sum   <= '0;
            hd_sum    <= '0;
            wce       <= '0;
        end else if (clr) begin
            stage_vld <= 1'b0;
            err_cnt   <= '0;
            abs_sum   <= '0;
            hd_sum    <= '0;
            wce       <= '0;
        end else begin
            stage_vld <= valid;
            if (valid) begin
                stage_a <= approx_in;
                stage_e <= exact_in;
            end
            if (stage_vld) begin
                err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, (abs_d != '0)};
                abs_sum <= abs_sum + SUM_W'(abs_d);
                hd_sum  <= hd_sum + SUM_W'(popcount_out(xor_d));
                if (abs_d > wce) begin
                    wce <= abs_d;
                end
            end
        end
    end

endmodule

// File: rtl/sad_err_eval.sv
// Exhaustive sweep controller: drives every stimulus vector and collects error metrics.
module sad_err_eval
    import sad_eval_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  vec_out,
    input  logic [OUT_W-1:0] approx_in,
    input  logic [OUT_W-1:0] exact_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] abs_sum,
    output logic [SUM_W-1:0] hd_sum,
    output logic [OUT_W-1:0] wce
);

    eval_state_t state;
    logic        acc_clr;
    logic        acc_valid;

    // Accumulator controls and the busy flag decoded from the current state.
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        acc_clr   = 1'b0;
        acc_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    acc_clr = start;
            RUN: begin
                acc_valid = !abort;
                busy      = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            default: ;
        endcase
    end

    // Sweep FSM and stimulus counter; the counter wraps to zero on the last vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            vec_out <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_out <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        vec_out <= '0;
                        state   <= IDLE;
                    end else begin
                        vec_out <= vec_out + 1'b1;
                        if (vec_out == '1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    vec_out <= '0;
                    state   <= abort ? IDLE : DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sad_err_acc u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (acc_clr),
        .valid     (acc_valid),
        .approx_in (approx_in),
        .exact_in  (exact_in),
        .err_cnt   (err_cnt),
        .abs_sum   (abs_sum),
        .hd_sum    (hd_sum),
        .wce       (wce)
    );

endmodule

// File: tb/tb_sad_err_eval.sv
// Self-checking bench: behavioural netlist models on vec_out, reference sums from a plain loop.
module tb_sad_err_eval;
    import sad_eval_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [IN_W-1:0]  vec_out;
    logic [OUT_W-1:0] approx_in;
    logic [OUT_W-1:0] exact_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_cnt;
    logic [SUM_W-1:0] abs_sum;
    logic [SUM_W-1:0] hd_sum;
    logic [OUT_W-1:0] wce;

    int          mode;
    logic [2:0]  lut [0:1023];
    int          n_vec;
    int          n_bad;

    sad_err_eval dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .vec_out   (vec_out),
        .approx_in (approx_in),
        .exact_in  (exact_in),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .abs_sum   (abs_sum),
        .hd_sum    (hd_sum),
        .wce       (wce)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden netlist: mirrors the low three bits, except the last-vector scenario.
    function automatic logic [2:0] ex_of(input int m, input int v);
        if (m == 2) return (v == 1023) ? 3'd7 : 3'd0;
        return 3'(v & 7);
    endfunction

    // Approximate netlist per scenario.
    function automatic logic [2:0] ap_of(input int m, input int v);
        case (m)
            1:       return ex_of(m, v) ^ 3'b001;
            2:       return 3'd0;
            3:       return lut[v];
            default: return ex_of(m, v);
        endcase
    endfunction

    always_comb begin
        exact_in  = ex_of(mode, int'(vec_out));
        approx_in = ap_of(mode, int'(vec_out));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_lut();
        for (int v = 0; v < 1024; v++) lut[v] = 3'($urandom_range(0, 7));
    endtask

    // Reference metrics over the full vector space for the active scenario.
    task automatic check_results(input string tag);
        int e_err, e_abs, e_hd, e_wce, a, e, d;
        e_err = 0; e_abs = 0; e_hd = 0; e_wce = 0;
        for (int v = 0; v < 1024; v++) begin
            a = int'(ap_of(mode, v));
            e = int'(ex_of(mode, v));
            d = (a > e) ? a - e : e - a;
            if (d != 0) e_err++;
            e_abs += d;
            e_hd  += $countones(ap_of(mode, v) ^ ex_of(mode, v));
            if (d > e_wce) e_wce = d;
        end
        check({tag, ".err_cnt"}, 32'(err_cnt), e_err);
        check({tag, ".abs_sum"}, 32'(abs_sum), e_abs);
        check({tag, ".hd_sum"},  32'(hd_sum),  e_hd);
        check({tag, ".wce"},     32'(wce),     e_wce);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".vec_out"}, 32'(vec_out), 0);
        check({tag, ".busy"},    32'(busy),    0);
        check({tag, ".done"},    32'(done),    0);
        check({tag, ".err_cnt"}, 32'(err_cnt), 0);
        check({tag, ".abs_sum"}, 32'(abs_sum), 0);
        check({tag, ".hd_sum"},  32'(hd_sum),  0);
        check({tag, ".wce"},     32'(wce),     0);
    endtask

    // One sweep: start sampled at E0, then 1100 observed cycles (bounded).
    task automatic sweep(input string tag, input int m, input bit restart, input int abort_at);
        int done_cnt, done_at;
        mode = m;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        check({tag, ".busy_rise"}, 32'(busy), 1);
        done_cnt = 0;
        done_at  = -1;
        for (int n = 1; n <= 1100; n++) begin
            start = restart && (n == 10 || n == 600);
            abort = (n == abort_at);
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (n == 5) check({tag, ".vec5"}, 32'(vec_out), 5);
            if (n == abort_at) begin
                check({tag, ".abort_busy"}, 32'(busy), 0);
                check({tag, ".abort_vec"},  32'(vec_out), 0);
            end
            if (abort_at < 0 && n == 1024) check({tag, ".busy_1024"}, 32'(busy), 1);
            if (abort_at < 0 && n == 1025) begin
                check({tag, ".busy_1025"}, 32'(busy), 0);
                check({tag, ".vec_wrap"},  32'(vec_out), 0);
            end
        end
        if (abort_at < 0) begin
            check({tag, ".done_cnt"}, done_cnt, 1);
            check({tag, ".done_at"},  done_at, 1026);
        end else begin
            check({tag, ".no_done"}, done_cnt, 0);
        end
    endtask

    initial begin
        int idle_busy, idle_done;
        n_vec = 0;
        n_bad = 0;
        mode  = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        fill_lut();
        #12;
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        sweep("tied", 0, 1'b0, -1);
        check_results("tied");

        sweep("xor1", 1, 1'b0, -1);
        check_results("xor1");

        sweep("last", 2, 1'b0, -1);
        check_results("last");

        sweep("rand_a", 3, 1'b0, -1);
        check_results("rand_a");

        sweep("restart", 3, 1'b1, -1);
        check_results("restart");

        fill_lut();
        sweep("abort", 3, 1'b0, 500);
        sweep("post_abort", 3, 1'b0, -1);
        check_results("post_abort");

        // Asynchronous reset in the middle of a sweep.
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (300) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle_busy = 0;
        idle_done = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy) idle_busy++;
            if (done) idle_done++;
        end
        check("rst_idle.busy", idle_busy, 0);
        check("rst_idle.done", idle_done, 0);
        check("rst_idle.vec",  32'(vec_out), 0);

        fill_lut();
        sweep("post_rst", 3, 1'b0, -1);
        check_results("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
